bit_serializer: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the sequence detector and drives its `data` input.
- Accepts `WIDTH`-bit words over a valid/ready handshake and emits them MSB-first, one bit per `clk`, on a registered serial output.
- Supports gapless back-to-back frames, so a pattern that spans a word boundary reaches the detector intact.
- Provides `data_valid` and `frame_done` so downstream logic can qualify and frame the stream.

---
 rtl/bit_serializer.sv | 89 ++++++++
 tb/tb_bit_serializer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first serializer with a valid/ready word load and gapless back-to-back frames.
// Define SERIALIZER_PARITY_EN to append one even-parity bit to every frame.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic accept, last, done_n;
`ifdef SERIALIZER_PARITY_EN
  logic par, par_n;
  assign last = state == PARITY;
`else
  assign last = state == SHIFT && cnt == LAST;
`endif
  assign load_ready = !reset && (state == IDLE || last);
  assign accept = load_valid && load_ready;
  // sr is cleared whenever the block goes idle, so its MSB doubles as the quiet-low serial output
  assign data = sr[WIDTH-1];
  assign data_valid = state != IDLE;
  assign busy = data_valid;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
`ifdef SERIALIZER_PARITY_EN
    par_n = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      cnt_n = '0;
      sr_n = load_data;
`ifdef SERIALIZER_PARITY_EN
      par_n = ^load_data;
`endif
    end else if (state == SHIFT && cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
      state_n = PARITY;
      sr_n = {par, {(WIDTH-1){1'b0}}};
`else
      state_n = IDLE;
      sr_n = '0;
`endif
    end else if (state == SHIFT) begin
      cnt_n = cnt + CW'(1);
      sr_n = sr << 1;
    end else if (state == PARITY) begin
      state_n = IDLE;
      sr_n = '0;
    end
`ifdef SERIALIZER_PARITY_EN
    done_n = state_n == PARITY;
`else
    done_n = state_n == SHIFT && cnt_n == LAST;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      frame_done <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      frame_done <= done_n;
`ifdef SERIALIZER_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: queue-based reference model plus directed literal frames and randomized traffic.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [FL-1:0] E_B0 = 9'b1011_0000_1;
  localparam logic [FL-1:0] E_0D = 9'b0000_1101_1;
  localparam logic [FL-1:0] E_A5 = 9'b1010_0101_0;
  localparam logic [FL-1:0] E_03 = 9'b0000_0011_0;
  localparam logic [2*FL-1:0] E_BB = 18'b0000_1011_1_1000_0000_1;
`else
  localparam int FL = W;
  localparam logic [FL-1:0] E_B0 = 8'b1011_0000;
  localparam logic [FL-1:0] E_0D = 8'b0000_1101;
  localparam logic [FL-1:0] E_A5 = 8'b1010_0101;
  localparam logic [FL-1:0] E_03 = 8'b0000_0011;
  localparam logic [2*FL-1:0] E_BB = 16'b0000_1011_1000_0000;
`endif
  logic clk = 0, reset = 1, load_valid = 0, load_ready, data, data_valid, busy, frame_done;
  logic [W-1:0] load_data = '0;
  int checks = 0, errors = 0;
  bit q[$];
  bit_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .data(data), .data_valid(data_valid), .busy(busy),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic bit m_ready();
    return !reset && q.size() <= 1;
  endfunction
  // Model: q holds every bit still to appear on data; its head is the bit on data now.
  always @(posedge reset) q.delete();
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      bit acc;
      acc = load_valid && q.size() <= 1;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) q.push_back(load_data[i]);
`ifdef SERIALIZER_PARITY_EN
        q.push_back(^load_data);
`endif
      end
    end
  end
  always @(negedge clk) begin
    chk("m_valid", data_valid, q.size() > 0);
    chk("m_busy", busy, q.size() > 0);
    chk("m_data", data, q.size() > 0 ? q[0] : 1'b0);
    chk("m_done", frame_done, q.size() == 1);
    chk("m_ready", load_ready, m_ready());
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [W-1:0] w, input logic [FL-1:0] exp, input string nm, input int stall_at);
    logic [FL-1:0] cap = '0;
    load_data = w;
    load_valid = 1;
    tick();
    load_valid = 0;
    for (int i = 0; i < FL; i++) begin
      cap = {cap[FL-2:0], data};
      chk({nm, "_dv"}, data_valid, 1);
      chk({nm, "_fd"}, frame_done, i == FL - 1);
      chk({nm, "_rdy"}, load_ready, i == FL - 1);
      if (i == stall_at) begin
        load_data = 8'hFF;
        load_valid = 1;
      end
      tick();
      load_valid = 0;
    end
    chk({nm, "_bits"}, cap, exp);
    chk({nm, "_idle"}, data_valid, 0);
  endtask
  initial begin
    logic [2*FL-1:0] cap2 = '0;
    logic [W-1:0] word;
    bit acc;
    #2;
    chk("rst_data", data, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_rdy", load_ready, 0);
    tick();
    reset = 0;
    #1;
    chk("rel_rdy", load_ready, 1);
    chk("rel_data", data, 0);
    frame(8'hB0, E_B0, "b0", -1);
    frame(8'hA5, E_A5, "stall", 2);
    frame(8'h03, E_03, "w03", -1);
    load_data = 8'h0B;
    load_valid = 1;
    tick();
    load_data = 8'h80;
    for (int i = 0; i < 2 * FL; i++) begin
      cap2 = {cap2[2*FL-2:0], data};
      chk("bb_dv", data_valid, 1);
      if (i == FL - 1) chk("bb_rdy", load_ready, 1);
      tick();
      if (i == FL - 1) load_valid = 0;
    end
    chk("bb_bits", cap2, E_BB);
    chk("bb_idle", data_valid, 0);
    load_data = 8'hB0;
    load_valid = 1;
    tick();
    load_valid = 0;
    tick();
    tick();
    tick();
    #2 reset = 1;
    #1;
    chk("mid_dv", data_valid, 0);
    chk("mid_data", data, 0);
    chk("mid_fd", frame_done, 0);
    chk("mid_rdy", load_ready, 0);
    tick();
    #2 reset = 0;
    #1;
    chk("mid_rel_rdy", load_ready, 1);
    chk("mid_rel_data", data, 0);
    chk("mid_rel_dv", data_valid, 0);
    frame(8'h0D, E_0D, "w0d", -1);
    word = W'($urandom);
    for (int c = 0; c < 600; c++) begin
      load_valid = $urandom_range(0, 3) != 0;
      load_data = word;
      if ($urandom_range(0, 63) == 0) begin
        #2 reset = 1;
        #4 reset = 0;
      end
      acc = load_valid && m_ready();
      tick();
      if (acc) word = W'($urandom);
    end
    load_valid = 0;
    repeat (FL + 2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
